// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with branch resolution.
// Captures the ALU result, store data, branch target and control bundle, and
// registers the PC redirect decision computed from the ALU flags and funct3.
module ex_mem_stage #(
   parameter int unsigned n = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         stall,
   input  logic         flush,
   input  logic         ex_valid,
   input  logic [n-1:0] ex_alu_result,
   input  logic         ex_zflag,
   input  logic         ex_sflag,
   input  logic         ex_cflag,
   input  logic         ex_vflag,
   input  logic [n-1:0] ex_rs2_data,
   input  logic [n-1:0] ex_branch_target,
   input  logic [4:0]   ex_rd,
   input  logic         ex_reg_write,
   input  logic         ex_mem_read,
   input  logic         ex_mem_write,
   input  logic         ex_branch,
   input  logic         ex_jump,
   input  logic [2:0]   ex_funct3,
   output logic         mem_valid,
   output logic [n-1:0] mem_alu_result,
   output logic [n-1:0] mem_rs2_data,
   output logic [n-1:0] mem_branch_target,
   output logic [4:0]   mem_rd,
   output logic         mem_reg_write,
   output logic         mem_mem_read,
   output logic         mem_mem_write,
   output logic [2:0]   mem_funct3,
   output logic         mem_pc_src
);

   logic         valid_q,     valid_d;
   logic [n-1:0] alu_q,       alu_d;
   logic [n-1:0] rs2_q,       rs2_d;
   logic [n-1:0] target_q,    target_d;
   logic [4:0]   rd_q,        rd_d;
   logic         reg_write_q, reg_write_d;
   logic         mem_read_q,  mem_read_d;
   logic         mem_write_q, mem_write_d;
   logic [2:0]   funct3_q,    funct3_d;
   logic         pc_src_q,    pc_src_d;
   logic         br_cond;

   // Branch condition from the flags of A-B; cflag=1 means no borrow (A >= B unsigned)
   always_comb begin
      br_cond = 1'b0;
      case (ex_funct3)
         3'b000:  br_cond = ex_zflag;
         3'b001:  br_cond = ~ex_zflag;
         3'b100:  br_cond = ex_sflag ^ ex_vflag;
         3'b101:  br_cond = ~(ex_sflag ^ ex_vflag);
         3'b110:  br_cond = ~ex_cflag;
         3'b111:  br_cond = ex_cflag;
         default: br_cond = 1'b0;
      endcase
   end

   // Next-entry selection: flush inserts a bubble, stall holds, otherwise load qualified EX bundle
   always_comb begin
      valid_d     = valid_q;
      alu_d       = alu_q;
      rs2_d       = rs2_q;
      target_d    = target_q;
      rd_d        = rd_q;
      reg_write_d = reg_write_q;
      mem_read_d  = mem_read_q;
      mem_write_d = mem_write_q;
      funct3_d    = funct3_q;
      pc_src_d    = pc_src_q;
      if (flush) begin
         valid_d     = 1'b0;
         alu_d       = '0;
         rs2_d       = '0;
         target_d    = '0;
         rd_d        = '0;
         reg_write_d = 1'b0;
         mem_read_d  = 1'b0;
         mem_write_d = 1'b0;
         funct3_d    = '0;
         pc_src_d    = 1'b0;
      end else if (!stall) begin
         valid_d     = ex_valid;
         alu_d       = ex_alu_result;
         rs2_d       = ex_rs2_data;
         target_d    = ex_branch_target;
         rd_d        = ex_rd;
         reg_write_d = ex_valid & ex_reg_write & (ex_rd != 5'd0);
         mem_read_d  = ex_valid & ex_mem_read;
         mem_write_d = ex_valid & ex_mem_write;
         funct3_d    = ex_funct3;
         pc_src_d    = ex_valid & (ex_jump | (ex_branch & br_cond));
      end
   end

   // Pipeline register with synchronous reset taking priority over everything
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q     <= 1'b0;
         alu_q       <= '0;
         rs2_q       <= '0;
         target_q    <= '0;
         rd_q        <= '0;
         reg_write_q <= 1'b0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         funct3_q    <= '0;
         pc_src_q    <= 1'b0;
      end else begin
         valid_q     <= valid_d;
         alu_q       <= alu_d;
         rs2_q       <= rs2_d;
         target_q    <= target_d;
         rd_q        <= rd_d;
         reg_write_q <= reg_write_d;
         mem_read_q  <= mem_read_d;
         mem_write_q <= mem_write_d;
         funct3_q    <= funct3_d;
         pc_src_q    <= pc_src_d;
      end
   end

   assign mem_valid         = valid_q;
   assign mem_alu_result    = alu_q;
   assign mem_rs2_data      = rs2_q;
   assign mem_branch_target = target_q;
   assign mem_rd            = rd_q;
   assign mem_reg_write     = reg_write_q;
   assign mem_mem_read      = mem_read_q;
   assign mem_mem_write     = mem_write_q;
   assign mem_funct3        = funct3_q;
   assign mem_pc_src        = pc_src_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: directed vector table, hand-written
// reset/stall/flush sequences, and randomized traffic against a reference model
// that resolves branches from the original operands rather than from flags.
module tb_ex_mem_stage;

   logic        clk = 1'b0;
   logic        rst, stall, flush, ex_valid;
   logic [31:0] ex_alu_result, ex_rs2_data, ex_branch_target;
   logic        ex_zflag, ex_sflag, ex_cflag, ex_vflag;
   logic [4:0]  ex_rd;
   logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump;
   logic [2:0]  ex_funct3;
   logic        mem_valid, mem_reg_write, mem_mem_read, mem_mem_write, mem_pc_src;
   logic [31:0] mem_alu_result, mem_rs2_data, mem_branch_target;
   logic [4:0]  mem_rd;
   logic [2:0]  mem_funct3;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   ex_mem_stage #(.n(32)) dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .ex_valid(ex_valid),
      .ex_alu_result(ex_alu_result), .ex_zflag(ex_zflag), .ex_sflag(ex_sflag),
      .ex_cflag(ex_cflag), .ex_vflag(ex_vflag), .ex_rs2_data(ex_rs2_data),
      .ex_branch_target(ex_branch_target), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
      .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_branch(ex_branch),
      .ex_jump(ex_jump), .ex_funct3(ex_funct3), .mem_valid(mem_valid),
      .mem_alu_result(mem_alu_result), .mem_rs2_data(mem_rs2_data),
      .mem_branch_target(mem_branch_target), .mem_rd(mem_rd),
      .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
      .mem_mem_write(mem_mem_write), .mem_funct3(mem_funct3), .mem_pc_src(mem_pc_src)
   );

   typedef struct packed {
      logic        rst, stall, flush, valid;
      logic [31:0] alu, rs2, tgt;
      logic        z, s, c, v;
      logic [4:0]  rd;
      logic        rw, mr, mw, br, jmp;
      logic [2:0]  f3;
   } stim_t;

   typedef struct packed {
      logic        valid, pc, rw, mr, mw;
      logic [31:0] alu, rs2, tgt;
      logic [4:0]  rd;
      logic [2:0]  f3;
   } exp_t;

   typedef struct packed {
      stim_t s;
      exp_t  e;
   } vec_t;

   task automatic drive(input stim_t s);
      rst = s.rst; stall = s.stall; flush = s.flush; ex_valid = s.valid;
      ex_alu_result = s.alu; ex_rs2_data = s.rs2; ex_branch_target = s.tgt;
      ex_zflag = s.z; ex_sflag = s.s; ex_cflag = s.c; ex_vflag = s.v;
      ex_rd = s.rd; ex_reg_write = s.rw; ex_mem_read = s.mr; ex_mem_write = s.mw;
      ex_branch = s.br; ex_jump = s.jmp; ex_funct3 = s.f3;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input exp_t e);
      chk({tag, "/valid"},  {31'd0, mem_valid},     {31'd0, e.valid});
      chk({tag, "/pc_src"}, {31'd0, mem_pc_src},    {31'd0, e.pc});
      chk({tag, "/rw"},     {31'd0, mem_reg_write}, {31'd0, e.rw});
      chk({tag, "/mr"},     {31'd0, mem_mem_read},  {31'd0, e.mr});
      chk({tag, "/mw"},     {31'd0, mem_mem_write}, {31'd0, e.mw});
      chk({tag, "/alu"},    mem_alu_result,         e.alu);
      chk({tag, "/rs2"},    mem_rs2_data,           e.rs2);
      chk({tag, "/tgt"},    mem_branch_target,      e.tgt);
      chk({tag, "/rd"},     {27'd0, mem_rd},        {27'd0, e.rd});
      chk({tag, "/f3"},     {29'd0, mem_funct3},    {29'd0, e.f3});
   endtask

   // Branch outcome from the actual operands, as the ISA defines it
   function automatic logic taken_of(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3);
      case (f3)
         3'b000:  return a == b;
         3'b001:  return a != b;
         3'b100:  return $signed(a) <  $signed(b);
         3'b101:  return $signed(a) >= $signed(b);
         3'b110:  return a <  b;
         3'b111:  return a >= b;
         default: return 1'b0;
      endcase
   endfunction

   function automatic exp_t model(input exp_t cur, input stim_t s, input logic taken);
      exp_t e;
      if (s.rst || s.flush) e = '0;
      else if (s.stall) e = cur;
      else begin
         e.valid = s.valid;
         e.pc    = s.valid & (s.jmp | (s.br & taken));
         e.rw    = s.valid & s.rw & (s.rd != 5'd0);
         e.mr    = s.valid & s.mr;
         e.mw    = s.valid & s.mw;
         e.alu   = s.alu; e.rs2 = s.rs2; e.tgt = s.tgt; e.rd = s.rd; e.f3 = s.f3;
      end
      return e;
   endfunction

   vec_t  vecs[12];
   stim_t st;
   exp_t  mdl;

   initial begin
      // rst stall flush valid alu rs2 tgt z s c v rd rw mr mw br jmp f3 | valid pc rw mr mw alu rs2 tgt rd f3
      vecs[0]  = '{'{1'b0,1'b0,1'b0,1'b1,32'hFFFF_FFFE,32'h11,32'h1000,1'b0,1'b1,1'b1,1'b0,5'd0,1'b0,1'b0,1'b0,1'b1,1'b0,3'b100},
                   '{1'b1,1'b1,1'b0,1'b0,1'b0,32'hFFFF_FFFE,32'h11,32'h1000,5'd0,3'b100}};
      vecs[1]  = '{'{1'b0,1'b0,1'b0,1'b1,32'hFFFF_FFFE,32'h12,32'h1004,1'b0,1'b1,1'b1,1'b0,5'd0,1'b0,1'b0,1'b0,1'b1,1'b0,3'b110},
                   '{1'b1,1'b0,1'b0,1'b0,1'b0,32'hFFFF_FFFE,32'h12,32'h1004,5'd0,3'b110}};
      vecs[2]  = '{'{1'b0,1'b0,1'b0,1'b1,32'h0,32'h13,32'h1008,1'b1,1'b0,1'b1,1'b0,5'd0,1'b0,1'b0,1'b0,1'b1,1'b0,3'b000},
                   '{1'b1,1'b1,1'b0,1'b0,1'b0,32'h0,32'h13,32'h1008,5'd0,3'b000}};
      vecs[3]  = '{'{1'b0,1'b0,1'b0,1'b1,32'h0,32'h14,32'h100C,1'b1,1'b0,1'b1,1'b0,5'd0,1'b0,1'b0,1'b0,1'b1,1'b0,3'b001},
                   '{1'b1,1'b0,1'b0,1'b0,1'b0,32'h0,32'h14,32'h100C,5'd0,3'b001}};
      vecs[4]  = '{'{1'b0,1'b0,1'b0,1'b1,32'h0,32'h15,32'h1010,1'b1,1'b1,1'b0,1'b0,5'd0,1'b0,1'b0,1'b0,1'b1,1'b0,3'b010},
                   '{1'b1,1'b0,1'b0,1'b0,1'b0,32'h0,32'h15,32'h1010,5'd0,3'b010}};
      vecs[5]  = '{'{1'b0,1'b0,1'b0,1'b1,32'h1234_5678,32'h16,32'h1014,1'b0,1'b0,1'b0,1'b0,5'd0,1'b1,1'b0,1'b0,1'b0,1'b0,3'b000},
                   '{1'b1,1'b0,1'b0,1'b0,1'b0,32'h1234_5678,32'h16,32'h1014,5'd0,3'b000}};
      vecs[6]  = '{'{1'b0,1'b0,1'b0,1'b1,32'h8765_4321,32'h17,32'h1018,1'b0,1'b0,1'b0,1'b0,5'd5,1'b1,1'b1,1'b0,1'b0,1'b0,3'b010},
                   '{1'b1,1'b0,1'b1,1'b1,1'b0,32'h8765_4321,32'h17,32'h1018,5'd5,3'b010}};
      vecs[7]  = '{'{1'b0,1'b0,1'b0,1'b1,32'h40,32'h18,32'h2000,1'b1,1'b0,1'b0,1'b0,5'd1,1'b0,1'b0,1'b1,1'b0,1'b1,3'b001},
                   '{1'b1,1'b1,1'b0,1'b0,1'b1,32'h40,32'h18,32'h2000,5'd1,3'b001}};
      vecs[8]  = '{'{1'b0,1'b0,1'b0,1'b0,32'h40,32'h18,32'h2000,1'b1,1'b0,1'b0,1'b0,5'd1,1'b1,1'b1,1'b1,1'b0,1'b1,3'b001},
                   '{1'b0,1'b0,1'b0,1'b0,1'b0,32'h40,32'h18,32'h2000,5'd1,3'b001}};
      vecs[9]  = '{'{1'b0,1'b0,1'b0,1'b1,32'h5,32'h19,32'h3000,1'b0,1'b0,1'b1,1'b0,5'd2,1'b0,1'b0,1'b0,1'b1,1'b1,3'b000},
                   '{1'b1,1'b1,1'b0,1'b0,1'b0,32'h5,32'h19,32'h3000,5'd2,3'b000}};
      vecs[10] = '{'{1'b0,1'b0,1'b0,1'b1,32'h7FFF_FFFF,32'h1A,32'h3004,1'b0,1'b1,1'b0,1'b1,5'd3,1'b0,1'b0,1'b0,1'b1,1'b0,3'b101},
                   '{1'b1,1'b1,1'b0,1'b0,1'b0,32'h7FFF_FFFF,32'h1A,32'h3004,5'd3,3'b101}};
      vecs[11] = '{'{1'b0,1'b0,1'b0,1'b1,32'h7FFF_FFFF,32'h1B,32'h3008,1'b0,1'b1,1'b0,1'b1,5'd3,1'b0,1'b0,1'b0,1'b1,1'b0,3'b111},
                   '{1'b1,1'b0,1'b0,1'b0,1'b0,32'h7FFF_FFFF,32'h1B,32'h3008,5'd3,3'b111}};

      // Reset with every input nonzero, held two cycles
      st = '{1'b1,1'b1,1'b1,1'b1,32'hFFFF_FFFF,32'hFFFF_FFFF,32'hFFFF_FFFF,1'b1,1'b1,1'b1,1'b1,5'd31,
             1'b1,1'b1,1'b1,1'b1,1'b1,3'b111};
      drive(st);
      step();
      st.stall = 1'b0; st.flush = 1'b0;
      drive(st);
      step();
      check_all("reset", '0);

      // First load after reset release
      st = '0;
      st.valid = 1'b1; st.alu = 32'h0000_0010;
      drive(st);
      step();
      mdl = model('0, st, 1'b0);
      chk("post_reset/alu",   mem_alu_result, 32'h10);
      chk("post_reset/valid", {31'd0, mem_valid}, 32'd1);

      // Directed vector table
      for (int i = 0; i < 12; i++) begin
         drive(vecs[i].s);
         step();
         check_all($sformatf("vec%0d", i), vecs[i].e);
      end

      // Load then stall three cycles with changing inputs: outputs hold
      st = '0;
      st.valid = 1'b1; st.alu = 32'hAAAA_5555; st.rs2 = 32'h77; st.tgt = 32'h400;
      st.rd = 5'd9; st.rw = 1'b1; st.mw = 1'b1; st.jmp = 1'b1; st.f3 = 3'b011;
      drive(st);
      step();
      mdl = model('0, st, 1'b0);
      check_all("hold_load", mdl);
      for (int i = 0; i < 3; i++) begin
         st.stall = 1'b1;
         st.alu = $urandom; st.rs2 = $urandom; st.tgt = $urandom;
         st.rd = 5'($urandom); st.jmp = 1'b0; st.f3 = 3'($urandom);
         drive(st);
         step();
         check_all($sformatf("stall%0d", i), mdl);
      end

      // Stall and flush together: bubble wins
      st.stall = 1'b1; st.flush = 1'b1;
      drive(st);
      step();
      check_all("stall_flush", '0);

      // Reset mid-stall after a fresh load
      st = '0; st.valid = 1'b1; st.alu = 32'h55; st.jmp = 1'b1; st.rd = 5'd4; st.rw = 1'b1;
      drive(st);
      step();
      st.rst = 1'b1; st.stall = 1'b1;
      drive(st);
      step();
      check_all("rst_stall", '0);
      mdl = '0;

      // Randomized traffic against the reference model
      for (int i = 0; i < 400; i++) begin
         logic [31:0] a, b, diff;
         logic [32:0] sum;
         logic        tk;
         a = $urandom;
         b = ($urandom_range(0, 3) == 0) ? a : 32'($urandom);
         if ($urandom_range(0, 3) == 0) b = a ^ 32'h8000_0000;
         diff = a - b;
         sum  = {1'b0, a} + {1'b0, ~b} + 33'd1;
         st.rst   = ($urandom_range(0, 63) == 0);
         st.stall = ($urandom_range(0, 7) == 0);
         st.flush = ($urandom_range(0, 15) == 0);
         st.valid = ($urandom_range(0, 4) != 0);
         st.alu   = diff;
         st.rs2   = $urandom;
         st.tgt   = $urandom;
         st.z     = (diff == 32'd0);
         st.s     = diff[31];
         st.c     = sum[32];
         st.v     = (a[31] != b[31]) && (diff[31] != a[31]);
         st.rd    = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
         st.rw    = 1'($urandom); st.mr = 1'($urandom); st.mw = 1'($urandom);
         st.br    = 1'($urandom); st.jmp = ($urandom_range(0, 5) == 0);
         st.f3    = 3'($urandom);
         tk = taken_of(a, b, st.f3);
         mdl = model(mdl, st, tk);
         drive(st);
         step();
         check_all($sformatf("rand%0d", i), mdl);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
